exc_flush_ctrl: RTL and testbench

Exception sequencing controller for the five-stage MIPS pipeline. It samples the exception flags, including the pipelined arithmetic overflow, that reach the MEM stage, and resolves them by priority. It records EPC, Cause and the EXL bit, then runs a fixed flush-and-redirect sequence. It drives the enable and flush inputs of every pipeline register and the PC-redirect path, and it also handles `eret` returns.

---
 rtl/exc_flush_ctrl_pkg.sv | 14 +
 rtl/exc_flush_ctrl_if.sv | 26 ++
 rtl/exc_flush_ctrl_cp0_regs.sv | 50 +++++
 rtl/exc_flush_ctrl.sv | 54 +++++
 tb/tb_exc_flush_ctrl.sv | 135 +++++++++++++
 5 files changed

// File: rtl/exc_flush_ctrl_pkg.sv
// exc_pkg: shared ExcCodes, FSM encoding, handler address and Cause bit positions for exc_flush_ctrl
package exc_pkg;
  localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_4180;
  localparam int NUM_HWINT = 6;
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI = 5'd10;
  localparam logic [4:0] EXC_OV = 5'd12;
  localparam int CAUSE_BD = 31;
  localparam int CAUSE_IP_LO = 10;
  localparam int CAUSE_EXC_LO = 2;
  typedef enum logic [2:0] {IDLE, EXC_FLUSH, EXC_REDIR, RET_FLUSH, RET_REDIR} state_t;
endpackage

// File: rtl/exc_flush_ctrl_if.sv
// exc_flush_ctrl_if: MEM-stage exception inputs and pipeline control/CP0 outputs
interface exc_flush_ctrl_if;
  import exc_pkg::*;
  logic m_valid;
  logic m_exc_valid;
  logic [4:0] m_exc_code;
  logic [31:0] m_pc;
  logic m_bd;
  logic m_eret;
  logic [NUM_HWINT-1:0] hwint;
  logic pipe_en;
  logic flush;
  logic redirect;
  logic [31:0] redirect_pc;
  logic [31:0] epc;
  logic [31:0] cause;
  logic exl;
  modport master (
    output m_valid, m_exc_valid, m_exc_code, m_pc, m_bd, m_eret, hwint,
    input pipe_en, flush, redirect, redirect_pc, epc, cause, exl
  );
  modport slave (
    input m_valid, m_exc_valid, m_exc_code, m_pc, m_bd, m_eret, hwint,
    output pipe_en, flush, redirect, redirect_pc, epc, cause, exl
  );
endinterface

// File: rtl/exc_flush_ctrl_cp0_regs.sv
// cp0_regs: EPC/Cause/EXL storage; Cause.IP sampled only when EXC_FLUSH_CTRL_INT_EN is defined
module cp0_regs
  import exc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic capture,
  input  logic is_int,
  input  logic clear,
  input  logic [4:0] code,
  input  logic [31:0] pc,
  input  logic bd,
  input  logic [NUM_HWINT-1:0] hwint,
  output logic [31:0] epc,
  output logic [31:0] cause,
  output logic exl
);
  logic bd_r;
  logic [4:0] code_r;
  logic [NUM_HWINT-1:0] ip_r;
`ifndef EXC_FLUSH_CTRL_INT_EN
  logic unused_hwint;
  assign unused_hwint = ^hwint;
`endif
  assign cause = {bd_r, 15'd0, ip_r, 3'd0, code_r, 2'd0};
  // nested exceptions keep the original EPC; eret only drops EXL
  always_ff @(posedge clk) begin
    if (reset) begin
      epc <= '0;
      bd_r <= 1'b0;
      code_r <= '0;
      ip_r <= '0;
      exl <= 1'b0;
    end else begin
`ifdef EXC_FLUSH_CTRL_INT_EN
      ip_r <= hwint;
`else
      ip_r <= '0;
`endif
      if (capture) begin
        bd_r <= bd;
        code_r <= is_int ? EXC_INT : code;
        if (!exl) epc <= bd ? pc - 32'd4 : pc;
        exl <= 1'b1;
      end else if (clear) begin
        exl <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/exc_flush_ctrl.sv
// exc_flush_ctrl: MEM-stage exception/eret flush-and-redirect sequencer (interrupts with EXC_FLUSH_CTRL_INT_EN)
module exc_flush_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF
) (
  input logic clk,
  input logic reset,
  exc_flush_ctrl_if.slave bus
);
  state_t state, state_n;
  logic take_exc, take_int, take_ret, idle;
  assign idle = state == IDLE;
  assign take_exc = bus.m_valid & bus.m_exc_valid;
`ifdef EXC_FLUSH_CTRL_INT_EN
  assign take_int = bus.m_valid & |bus.hwint & ~bus.exl;
`else
  assign take_int = 1'b0;
`endif
  assign take_ret = bus.m_valid & bus.m_eret & ~bus.m_exc_valid;
  cp0_regs u_cp0 (
    .clk(clk),
    .reset(reset),
    .capture(idle & (take_exc | take_int)),
    .is_int(~take_exc),
    .clear(idle & ~take_exc & ~take_int & take_ret),
    .code(bus.m_exc_code),
    .pc(bus.m_pc),
    .bd(bus.m_bd),
    .hwint(bus.hwint),
    .epc(bus.epc),
    .cause(bus.cause),
    .exl(bus.exl)
  );
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // next state and per-state pipeline control decode
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE: state_n = (take_exc | take_int) ? EXC_FLUSH : take_ret ? RET_FLUSH : IDLE;
      EXC_FLUSH: state_n = EXC_REDIR;
      RET_FLUSH: state_n = RET_REDIR;
      default: state_n = IDLE;
    endcase
    bus.pipe_en = idle;
    bus.flush = (state == EXC_FLUSH) | (state == RET_FLUSH);
    bus.redirect = (state == EXC_REDIR) | (state == RET_REDIR);
    bus.redirect_pc = (state == EXC_REDIR) ? HANDLER_ADDR : (state == RET_REDIR) ? bus.epc : 32'd0;
  end
endmodule

// File: tb/tb_exc_flush_ctrl.sv
// tb_exc_flush_ctrl: table-driven check of exc_flush_ctrl plus reset and interrupt sequences
module tb_exc_flush_ctrl;
`ifdef EXC_FLUSH_CTRL_INT_EN
  localparam bit INT_ON = 1'b1;
`else
  localparam bit INT_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_fail = 0;
  exc_flush_ctrl_if bus ();
  exc_flush_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic v, ev;
    logic [4:0] code;
    logic [31:0] pc;
    logic bd, er;
    logic pe, fl, rd;
    logic [31:0] rpc, epc, cause;
    logic exl;
  } vec_t;
  vec_t tv[27];
  function automatic vec_t mk(logic v, logic ev, logic [4:0] code, logic [31:0] pc, logic bd, logic er,
                              logic pe, logic fl, logic rd, logic [31:0] rpc, logic [31:0] epc,
                              logic [31:0] cause, logic exl);
    vec_t r;
    r.v = v; r.ev = ev; r.code = code; r.pc = pc; r.bd = bd; r.er = er;
    r.pe = pe; r.fl = fl; r.rd = rd; r.rpc = rpc; r.epc = epc; r.cause = cause; r.exl = exl;
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic v, input logic ev, input logic [4:0] code, input logic [31:0] pc,
                       input logic bd, input logic er, input logic [5:0] hw);
    bus.m_valid = v; bus.m_exc_valid = ev; bus.m_exc_code = code;
    bus.m_pc = pc; bus.m_bd = bd; bus.m_eret = er; bus.hwint = hw;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_all(input string tag, input logic pe, input logic fl, input logic rd,
                         input logic [31:0] rpc, input logic [31:0] epc, input logic [31:0] cause,
                         input logic exl);
    chk({tag, ".pipe_en"}, {31'd0, bus.pipe_en}, {31'd0, pe});
    chk({tag, ".flush"}, {31'd0, bus.flush}, {31'd0, fl});
    chk({tag, ".redirect"}, {31'd0, bus.redirect}, {31'd0, rd});
    chk({tag, ".redirect_pc"}, bus.redirect_pc, rpc);
    chk({tag, ".epc"}, bus.epc, epc);
    chk({tag, ".cause"}, bus.cause, cause);
    chk({tag, ".exl"}, {31'd0, bus.exl}, {31'd0, exl});
  endtask
  initial begin
    tv[0]  = mk(0, 0, 0,  32'h0,    0, 0, 1, 0, 0, 32'h0,    32'h0,         32'h0,         0);
    tv[1]  = mk(0, 1, 12, 32'h3010, 0, 0, 1, 0, 0, 32'h0,    32'h0,         32'h0,         0);
    tv[2]  = mk(1, 1, 12, 32'h3010, 0, 0, 0, 1, 0, 32'h0,    32'h3010,      32'h30,        1);
    tv[3]  = mk(0, 0, 0,  32'h0,    0, 0, 0, 0, 1, 32'h4180, 32'h3010,      32'h30,        1);
    tv[4]  = mk(0, 0, 0,  32'h0,    0, 0, 1, 0, 0, 32'h0,    32'h3010,      32'h30,        1);
    tv[5]  = mk(1, 0, 0,  32'h5000, 0, 1, 0, 1, 0, 32'h0,    32'h3010,      32'h30,        0);
    tv[6]  = mk(0, 0, 0,  32'h0,    0, 0, 0, 0, 1, 32'h3010, 32'h3010,      32'h30,        0);
    tv[7]  = mk(0, 0, 0,  32'h0,    0, 0, 1, 0, 0, 32'h0,    32'h3010,      32'h30,        0);
    tv[8]  = mk(1, 1, 4,  32'h3024, 1, 0, 0, 1, 0, 32'h0,    32'h3020,      32'h8000_0010, 1);
    tv[9]  = mk(0, 0, 0,  32'h0,    0, 0, 0, 0, 1, 32'h4180, 32'h3020,      32'h8000_0010, 1);
    tv[10] = mk(0, 0, 0,  32'h0,    0, 0, 1, 0, 0, 32'h0,    32'h3020,      32'h8000_0010, 1);
    tv[11] = mk(1, 1, 12, 32'h4190, 0, 0, 0, 1, 0, 32'h0,    32'h3020,      32'h30,        1);
    tv[12] = mk(1, 0, 0,  32'h4194, 0, 1, 0, 0, 1, 32'h4180, 32'h3020,      32'h30,        1);
    tv[13] = mk(1, 1, 10, 32'h9000, 0, 0, 1, 0, 0, 32'h0,    32'h3020,      32'h30,        1);
    tv[14] = mk(1, 0, 0,  32'h4200, 0, 1, 0, 1, 0, 32'h0,    32'h3020,      32'h30,        0);
    tv[15] = mk(0, 0, 0,  32'h0,    0, 0, 0, 0, 1, 32'h3020, 32'h3020,      32'h30,        0);
    tv[16] = mk(0, 0, 0,  32'h0,    0, 0, 1, 0, 0, 32'h0,    32'h3020,      32'h30,        0);
    tv[17] = mk(1, 1, 10, 32'h3100, 0, 1, 0, 1, 0, 32'h0,    32'h3100,      32'h28,        1);
    tv[18] = mk(0, 0, 0,  32'h0,    0, 0, 0, 0, 1, 32'h4180, 32'h3100,      32'h28,        1);
    tv[19] = mk(0, 0, 0,  32'h0,    0, 0, 1, 0, 0, 32'h0,    32'h3100,      32'h28,        1);
    tv[20] = mk(0, 0, 0,  32'h4300, 0, 1, 1, 0, 0, 32'h0,    32'h3100,      32'h28,        1);
    tv[21] = mk(1, 0, 0,  32'h4300, 0, 1, 0, 1, 0, 32'h0,    32'h3100,      32'h28,        0);
    tv[22] = mk(0, 0, 0,  32'h0,    0, 0, 0, 0, 1, 32'h3100, 32'h3100,      32'h28,        0);
    tv[23] = mk(0, 0, 0,  32'h0,    0, 0, 1, 0, 0, 32'h0,    32'h3100,      32'h28,        0);
    tv[24] = mk(1, 1, 4,  32'h2,    1, 0, 0, 1, 0, 32'h0,    32'hFFFF_FFFE, 32'h8000_0010, 1);
    tv[25] = mk(0, 0, 0,  32'h0,    0, 0, 0, 0, 1, 32'h4180, 32'hFFFF_FFFE, 32'h8000_0010, 1);
    tv[26] = mk(0, 0, 0,  32'h0,    0, 0, 1, 0, 0, 32'h0,    32'hFFFF_FFFE, 32'h8000_0010, 1);
    drive(0, 0, 0, 0, 0, 0, 6'd0);
    step;
    step;
    chk_all("reset", 1, 0, 0, 32'h0, 32'h0, 32'h0, 0);
    reset = 1'b0;
    for (int i = 0; i < 27; i++) begin
      drive(tv[i].v, tv[i].ev, tv[i].code, tv[i].pc, tv[i].bd, tv[i].er, 6'd0);
      step;
      chk_all($sformatf("row%0d", i), tv[i].pe, tv[i].fl, tv[i].rd, tv[i].rpc, tv[i].epc, tv[i].cause, tv[i].exl);
    end
    drive(1, 1, 12, 32'h3010, 0, 0, 6'd0);
    step;
    chk("rst_seq.flush_before", {31'd0, bus.flush}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 6'd0);
    reset = 1'b1;
    step;
    chk_all("rst_seq.after", 1, 0, 0, 32'h0, 32'h0, 32'h0, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      chk($sformatf("rst_seq.no_redirect%0d", i), {31'd0, bus.redirect}, 32'd0);
      chk($sformatf("rst_seq.pipe_en%0d", i), {31'd0, bus.pipe_en}, 32'd1);
    end
    drive(1, 0, 0, 32'h3200, 0, 0, 6'b000100);
    step;
    chk_all("int.take", INT_ON ? 1'b0 : 1'b1, INT_ON, 0, 32'h0,
            INT_ON ? 32'h3200 : 32'h0, INT_ON ? 32'h1000 : 32'h0, INT_ON);
    drive(0, 0, 0, 0, 0, 0, 6'b000001);
    step;
    chk("int.redirect", {31'd0, bus.redirect}, {31'd0, INT_ON});
    chk("int.redirect_pc", bus.redirect_pc, INT_ON ? 32'h4180 : 32'h0);
    step;
    drive(1, 0, 0, 32'h4188, 0, 0, 6'b000001);
    step;
    chk_all("int.masked", 1, 0, 0, 32'h0, INT_ON ? 32'h3200 : 32'h0, INT_ON ? 32'h400 : 32'h0, INT_ON);
    drive(1, 1, 12, 32'h4190, 0, 0, 6'b000001);
    step;
    chk_all("nested.flush", 0, 1, 0, 32'h0, INT_ON ? 32'h3200 : 32'h4190, INT_ON ? 32'h430 : 32'h30, 1);
    drive(0, 0, 0, 0, 0, 0, 6'd0);
    step;
    chk("nested.redirect", {31'd0, bus.redirect}, 32'd1);
    chk("nested.redirect_pc", bus.redirect_pc, 32'h4180);
    step;
    chk("nested.idle", {31'd0, bus.pipe_en}, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
